// File: rtl/nios2_mul_result_assembler.sv
// nios2_mul_result_assembler: builds the Nios II MUL/MULX result from the three registered
// 16x16 partial products, computing hi*hi iteratively and applying the signed corrections.
module nios2_mul_result_assembler #(
    parameter int BITS_PER_ITER = 1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        flush_i,
    input  logic [31:0] mul_cell_p1_i,
    input  logic [31:0] mul_cell_p2_i,
    input  logic [31:0] mul_cell_p3_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o
);
    localparam int N = 16 / BITS_PER_ITER;

    typedef enum logic [1:0] {IDLE, CAPT, ITER, FIN} state_e;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] src1_q, src2_q, p1_q, p2_q, p3_q, acc_q, result_q;
    logic [15:0] mcand_q, mplier_q;
    logic [3:0]  cnt_q;
    logic        done_q;

    logic [31:0] pp, acc_d, hu, corr1, corr2, res_d;
    logic [4:0]  sh;
    logic [1:0]  carry;

    always_comb begin
        sh    = 5'(cnt_q) * 5'(BITS_PER_ITER);
        pp    = 32'(mcand_q) * 32'(mplier_q[BITS_PER_ITER-1:0]);
        acc_d = acc_q + (pp << sh);
        // carry out of the middle 16-bit column feeds the high word
        carry = 2'((18'(p1_q[31:16]) + 18'(p2_q[15:0]) + 18'(p3_q[15:0])) >> 16);
        hu    = acc_q + 32'(p2_q[31:16]) + 32'(p3_q[31:16]) + 32'(carry);
        corr1 = src1_q[31] ? src2_q : '0;
        corr2 = src2_q[31] ? src1_q : '0;
        res_d = op_q == 2'd0 ? p1_q + ((p2_q + p3_q) << 16) :
                op_q == 2'd1 ? hu :
                op_q == 2'd2 ? hu - corr1 : hu - corr1 - corr2;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        op_q    <= op_i;
                        src1_q  <= src1_i;
                        src2_q  <= src2_i;
                        state_q <= CAPT;
                    end
                    CAPT: begin
                        p1_q     <= mul_cell_p1_i;
                        p2_q     <= mul_cell_p2_i;
                        p3_q     <= mul_cell_p3_i;
                        mcand_q  <= src1_q[31:16];
                        mplier_q <= src2_q[31:16];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= op_q == 2'd0 ? FIN : ITER;
                    end
                    ITER: begin
                        acc_q    <= acc_d;
                        mplier_q <= mplier_q >> BITS_PER_ITER;
                        cnt_q    <= cnt_q + 4'd1;
                        if (cnt_q == 4'(N - 1)) state_q <= FIN;
                    end
                    FIN: begin
                        result_q <= res_d;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;
    assign busy_o   = state_q != IDLE;
endmodule

// File: tb/tb_nios2_mul_result_assembler.sv
// tb_nios2_mul_result_assembler: scoreboard bench driving a B=1 and a B=4 instance
// independently, with a 64-bit product reference model.
module tb_nios2_mul_result_assembler;
    typedef struct packed {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk, reset_n;
    logic        start_r[2], flush_r[2], done_w[2], busy_w[2], prev_d[2];
    logic [1:0]  op_r[2];
    logic [31:0] a_r[2], b_r[2], p1_r[2], p2_r[2], p3_r[2], res_w[2], last_res[2];
    exp_t        q0[$], q1[$];
    int          cyc, checks, errors;
    logic [31:0] corners[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    nios2_mul_result_assembler #(.BITS_PER_ITER(1)) u0 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_r[0]), .op_i(op_r[0]),
        .src1_i(a_r[0]), .src2_i(b_r[0]), .flush_i(flush_r[0]),
        .mul_cell_p1_i(p1_r[0]), .mul_cell_p2_i(p2_r[0]), .mul_cell_p3_i(p3_r[0]),
        .result_o(res_w[0]), .done_o(done_w[0]), .busy_o(busy_w[0]));

    nios2_mul_result_assembler #(.BITS_PER_ITER(4)) u1 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_r[1]), .op_i(op_r[1]),
        .src1_i(a_r[1]), .src2_i(b_r[1]), .flush_i(flush_r[1]),
        .mul_cell_p1_i(p1_r[1]), .mul_cell_p2_i(p2_r[1]), .mul_cell_p3_i(p3_r[1]),
        .result_o(res_w[1]), .done_o(done_w[1]), .busy_o(busy_w[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, b);
        logic        sa, sb;
        logic [63:0] p;
        sa = (o >= 2'd2) & a[31];
        sb = (o == 2'd3) & b[31];
        p  = {{32{sa}}, a} * {{32{sb}}, b};
        return o == 2'd0 ? p[31:0] : p[63:32];
    endfunction

    function automatic int lat(input int s, input logic [1:0] o);
        return o == 2'd0 ? 3 : (s == 0 ? 19 : 7);
    endfunction

    function automatic int qsize(input int s);
        return s == 0 ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input int s, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, s, got, exp);
        end
    endtask

    task automatic mon(input int s, input logic d, input logic b, input logic [31:0] r);
        exp_t e;
        if (d) begin
            checks++;
            if (qsize(s) == 0) begin
                errors++;
                $display("FAIL unexpected_done dut%0d cyc %0d: got result %h expected no done", s, cyc, r);
            end else begin
                if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (r !== e.res || cyc != e.cyc || b !== 1'b0) begin
                    errors++;
                    $display("FAIL op_done dut%0d: got result %h cyc %0d busy %b expected result %h cyc %0d busy 0",
                             s, r, cyc, b, e.res, e.cyc);
                end
                last_res[s] = e.res;
            end
            checks++;
            if (prev_d[s]) begin
                errors++;
                $display("FAIL double_done dut%0d cyc %0d: got done on two cycles expected one", s, cyc);
            end
        end else if (qsize(s) != 0) begin
            e = s == 0 ? q0[0] : q1[0];
            if (cyc > e.cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_done dut%0d: got no done by cyc %0d expected done in cyc %0d", s, cyc, e.cyc);
                if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        prev_d[s] = d;
    endtask

    always @(negedge clk) begin
        mon(0, done_w[0], busy_w[0], res_w[0]);
        mon(1, done_w[1], busy_w[1], res_w[1]);
    end

    // Drives start in the current cycle and the cell products in the next one only.
    task automatic issue(input int s, input logic [1:0] o, input logic [31:0] a, b, output int n);
        exp_t e;
        n     = cyc;
        e.res = ref_res(o, a, b);
        e.cyc = cyc + lat(s, o);
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        start_r[s] = 1'b1; op_r[s] = o; a_r[s] = a; b_r[s] = b;
        @(posedge clk); #1;
        start_r[s] = 1'b0; op_r[s] = 2'($urandom); a_r[s] = $urandom; b_r[s] = $urandom;
        p1_r[s] = 32'(a[15:0]) * 32'(b[15:0]);
        p2_r[s] = 32'(a[15:0]) * 32'(b[31:16]);
        p3_r[s] = 32'(a[31:16]) * 32'(b[15:0]);
        @(posedge clk); #1;
        p1_r[s] = $urandom; p2_r[s] = $urandom; p3_r[s] = $urandom;
    endtask

    task automatic goto(input int s, input int target, input logic junk);
        while (cyc < target) begin
            if (junk) begin
                start_r[s] = cyc[0]; op_r[s] = 2'($urandom); a_r[s] = $urandom; b_r[s] = $urandom;
            end
            @(posedge clk); #1;
        end
        start_r[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int t = 0;
        while (qsize(s) != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (qsize(s) != 0) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: got %0d pending ops expected 0", s, qsize(s));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] o;
        logic [31:0] a, b;
        cyc = 0; checks = 0; errors = 0; reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_r[s] = 0; flush_r[s] = 0; op_r[s] = 0; a_r[s] = 0; b_r[s] = 0;
            p1_r[s] = 0; p2_r[s] = 0; p3_r[s] = 0; prev_d[s] = 0; last_res[s] = 0;
        end
        #3;
        for (int s = 0; s < 2; s++) begin
            chk("reset_result", s, res_w[s], 32'h0);
            chk("reset_done", s, 32'(done_w[s]), 32'h0);
            chk("reset_busy", s, 32'(busy_w[s]), 32'h0);
        end
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 2; s++) begin
            issue(s, 2'd0, 32'h00010003, 32'h00020005, n);
            chk("busy_after_start", s, 32'(busy_w[s]), 32'h1);
            wait_idle(s);
            issue(s, 2'd1, 32'h00010003, 32'h00020005, n); wait_idle(s);
            for (int k = 0; k < 4; k++) begin
                issue(s, 2'(k), 32'hFFFFFFFF, 32'hFFFFFFFF, n); wait_idle(s);
            end
            issue(s, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
            goto(s, n + lat(s, 2'd3), 1'b1);
            issue(s, 2'd0, 32'h7FFFFFFF, 32'h00000002, n); wait_idle(s);
            issue(s, 2'd1, $urandom, $urandom, n);
            goto(s, n + 2 + (s == 0 ? 4 : 2), 1'b0);
            if (s == 0) void'(q0.pop_back()); else void'(q1.pop_back());
            flush_r[s] = 1'b1;
            @(posedge clk); #1;
            flush_r[s] = 1'b0;
            chk("flush_busy", s, 32'(busy_w[s]), 32'h0);
            goto(s, cyc + 25, 1'b0);
            chk("flush_result_held", s, res_w[s], last_res[s]);
            start_r[s] = 1'b1; flush_r[s] = 1'b1; op_r[s] = 2'd0;
            @(posedge clk); #1;
            start_r[s] = 1'b0; flush_r[s] = 1'b0;
            chk("start_flush_busy", s, 32'(busy_w[s]), 32'h0);
            goto(s, cyc + 10, 1'b0);
            chk("start_flush_result", s, res_w[s], last_res[s]);
        end

        issue(0, 2'd1, 32'h00010003, 32'h00020005, n);
        goto(0, n + 6, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("midop_reset_result", s, res_w[s], 32'h0);
            chk("midop_reset_done", s, 32'(done_w[s]), 32'h0);
            chk("midop_reset_busy", s, 32'(busy_w[s]), 32'h0);
            last_res[s] = 32'h0;
        end
        q0.delete(); q1.delete();
        @(posedge clk); @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        goto(0, cyc + 25, 1'b0);
        issue(0, 2'd1, 32'h00010003, 32'h00020005, n); wait_idle(0);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 30; k++) begin
                o = 2'($urandom_range(3));
                a = $urandom_range(3) == 0 ? corners[$urandom_range(3)] : $urandom;
                b = $urandom_range(3) == 0 ? corners[$urandom_range(3)] : $urandom;
                issue(s, o, a, b, n);
                if ($urandom_range(1) == 1 && k != 29) begin
                    goto(s, n + lat(s, o), 1'b1);
                end else begin
                    wait_idle(s);
                    goto(s, cyc + $urandom_range(2), 1'b0);
                end
            end
        end
        goto(0, cyc + 5, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
